// File: rtl/sram_arbiter.sv
// Arbitrates one asynchronous SRAM between display reads and game writes.
// Reads win by default; a pending write is forced through after STARVE_MAX reads.
module sram_arbiter #(
   parameter int STARVE_MAX = 8
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_rd_req,
   input  logic [19:0] i_rd_addr,
   output logic        o_rd_gnt,
   output logic [15:0] o_rd_data,
   output logic        o_rd_valid,
   input  logic        i_wr_req,
   input  logic [19:0] i_wr_addr,
   input  logic [15:0] i_wr_data,
   output logic        o_wr_gnt,
   output logic [19:0] o_SRAM_ADDR,
   inout  wire  [15:0] io_SRAM_DQ,
   output logic        o_SRAM_WE_N
);

   localparam int CW = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {IDLE, READ, WRITE, TURN} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] starve;
   logic [15:0]   wr_hold;
   logic          can_gnt;
   logic          wr_first;

   // The data bus belongs to the arbiter only during the WE_N-low cycle.
   assign io_SRAM_DQ = (state == WRITE) ? wr_hold : 16'hzzzz;

   // Grant selection and next state; WRITE always falls through to TURN.
   always_comb begin
      o_rd_gnt  = 1'b0;
      o_wr_gnt  = 1'b0;
      state_nxt = IDLE;
      can_gnt   = i_rst_n && (state != WRITE);
      wr_first  = i_wr_req && (starve == CW'(STARVE_MAX));
      if (can_gnt && i_rd_req && !wr_first) begin
         o_rd_gnt = 1'b1;
      end else if (can_gnt && i_wr_req) begin
         o_wr_gnt = 1'b1;
      end
      unique case (state)
         WRITE:   state_nxt = TURN;
         IDLE,
         READ,
         TURN: begin
            if (o_rd_gnt) begin
               state_nxt = READ;
            end else if (o_wr_gnt) begin
               state_nxt = WRITE;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // SRAM address/control launch; the address holds until the next grant.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_SRAM_ADDR <= '0;
         o_SRAM_WE_N <= 1'b1;
         wr_hold     <= '0;
      end else begin
         o_SRAM_WE_N <= !o_wr_gnt;
         if (o_rd_gnt) begin
            o_SRAM_ADDR <= i_rd_addr;
         end else if (o_wr_gnt) begin
            o_SRAM_ADDR <= i_wr_addr;
            wr_hold     <= i_wr_data;
         end
      end
   end

   // Capture the SRAM word at the end of each READ cycle.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_rd_data  <= '0;
         o_rd_valid <= 1'b0;
      end else begin
         o_rd_valid <= (state == READ);
         if (state == READ) begin
            o_rd_data <= io_SRAM_DQ;
         end
      end
   end

   // Count reads granted past a waiting write, saturating at the limit.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         starve <= '0;
      end else if (!i_wr_req || o_wr_gnt) begin
         starve <= '0;
      end else if (o_rd_gnt && starve != CW'(STARVE_MAX)) begin
         starve <= starve + 1'b1;
      end
   end

endmodule
